// File: rtl/ddr_clk_pkg.sv
`default_nettype none
// ============================================================================
// ddr_clk_pkg : shared types and phase-distance helper for the DDR clock PLL
// Rev 1.0
// ============================================================================
package ddr_clk_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    PLAN      = 3'd2,
    STEP_HI   = 3'd3,
    SETTLE    = 3'd4,
    FAULT     = 3'd5
  } phase_state_t;

  localparam int DIST_W          = 16;
  localparam int NOM_PHASE_STEPS = 16;
  localparam int DEG_PER_STEP    = 360 / NOM_PHASE_STEPS;

  // Returns {updn, k}: shortest wrap-around path from cur to tgt; a half-turn goes up.
  function automatic logic [DIST_W:0] phase_dist(input int unsigned cur,
                                                 input int unsigned tgt,
                                                 input int unsigned n);
    int unsigned d;
    d = (tgt >= cur) ? (tgt - cur) : (tgt + n - cur);
    if (d <= n / 2) return {1'b1, DIST_W'(d)};
    else            return {1'b0, DIST_W'(n - d)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_phase_distance.sv
`default_nettype none
// ============================================================================
// ddr_phase_distance : combinational direction/step-count from current to target
// Rev 1.0
// ============================================================================
module ddr_phase_distance
  import ddr_clk_pkg::*;
#(
  parameter int PHASE_STEPS = 16,
  parameter int PHASE_W     = $clog2(PHASE_STEPS)
) (
  input  logic [PHASE_W-1:0] cur_i,
  input  logic [PHASE_W-1:0] tgt_i,
  output logic               updn_o,
  output logic [PHASE_W:0]   k_o
);

  logic [DIST_W:0] w_dist;
  logic            w_unused;

  assign w_dist   = phase_dist(32'(cur_i), 32'(tgt_i), PHASE_STEPS);
  assign updn_o   = w_dist[DIST_W];
  assign k_o      = w_dist[PHASE_W:0];
  assign w_unused = ^w_dist[DIST_W-1:PHASE_W+1];

endmodule
`default_nettype wire

// File: rtl/ddr_phase_step_ctrl.sv
`default_nettype none
// ============================================================================
// ddr_phase_step_ctrl : drives PLL phase_step/phase_updn to reach a requested phase
// Rev 1.0
// ============================================================================
module ddr_phase_step_ctrl
  import ddr_clk_pkg::*;
#(
  parameter int PHASE_STEPS    = 16,
  parameter int PHASE_W        = $clog2(PHASE_STEPS),
  parameter int RESET_PHASE    = 4,
  parameter int STEP_PULSE_CYC = 2,
  parameter int SETTLE_CYC     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_rel,
  input  logic [PHASE_W-1:0] req_phase,
  output logic               phase_step,
  output logic               phase_updn,
  output logic [PHASE_W-1:0] cur_phase,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_MAX = (STEP_PULSE_CYC > SETTLE_CYC) ? STEP_PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int K_W     = PHASE_W + 1;
  localparam int SUM_W   = PHASE_W + 2;

  localparam logic [PHASE_W-1:0] c_RST_PH   = PHASE_W'(RESET_PHASE);
  localparam logic [PHASE_W-1:0] c_LAST_PH  = PHASE_W'(PHASE_STEPS - 1);
  localparam logic [CNT_W-1:0]   c_PULSE_LD = CNT_W'(STEP_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   c_SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  phase_state_t       state_q, state_d;
  logic [PHASE_W-1:0] cur_q, cur_d;
  logic [PHASE_W-1:0] req_q, req_d;
  logic               rel_q, rel_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               updn_q, updn_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic signed [SUM_W-1:0] w_sum;
  logic [PHASE_W-1:0]      w_tgt;
  logic                    w_updn;
  logic [K_W-1:0]          w_k;
  logic                    w_abs_oor;

  // Relative target: one add/sub of N suffices since |offset| < N.
  always_comb begin
    w_sum = $signed({2'b00, cur_q}) + $signed({{2{req_q[PHASE_W-1]}}, req_q});
    if (w_sum < 0)
      w_sum = w_sum + $signed(SUM_W'(PHASE_STEPS));
    else if (w_sum >= $signed(SUM_W'(PHASE_STEPS)))
      w_sum = w_sum - $signed(SUM_W'(PHASE_STEPS));
    w_tgt = rel_q ? w_sum[PHASE_W-1:0] : req_q;
  end

  assign w_abs_oor = !rel_q && ({1'b0, req_q} >= K_W'(PHASE_STEPS));

  ddr_phase_distance #(
    .PHASE_STEPS(PHASE_STEPS),
    .PHASE_W    (PHASE_W)
  ) u_dist (
    .cur_i (cur_q),
    .tgt_i (w_tgt),
    .updn_o(w_updn),
    .k_o   (w_k)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    req_d   = req_q;
    rel_d   = rel_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    updn_d  = updn_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cur_d = c_RST_PH;
        if (pll_locked) state_d = IDLE;
      end
      IDLE: begin
        if (!pll_locked) begin
          state_d = WAIT_LOCK;
          cur_d   = c_RST_PH;
        end else if (req_valid && req_ready) begin
          rel_d   = req_rel;
          req_d   = req_phase;
          err_d   = 1'b0;
          state_d = PLAN;
        end
      end
      PLAN: begin
        if (w_abs_oor) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          updn_d = w_updn;
          k_d    = w_k;
          if (w_k == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = c_PULSE_LD;
            state_d = STEP_HI;
          end
        end
      end
      STEP_HI, SETTLE: begin
        if (!pll_locked) begin
          state_d = FAULT;
          err_d   = 1'b1;
          done_d  = 1'b1;
          cur_d   = c_RST_PH;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (state_q == STEP_HI) begin
          if (updn_q) cur_d = (cur_q == c_LAST_PH) ? '0 : cur_q + 1'b1;
          else        cur_d = (cur_q == '0) ? c_LAST_PH : cur_q - 1'b1;
          k_d     = k_q - 1'b1;
          cnt_d   = c_SETTLE_LD;
          state_d = SETTLE;
        end else if (k_q != '0) begin
          cnt_d   = c_PULSE_LD;
          state_d = STEP_HI;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      FAULT:   state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cur_q   <= c_RST_PH;
      req_q   <= '0;
      rel_q   <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      updn_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      req_q   <= req_d;
      rel_q   <= rel_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      updn_q  <= updn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Step is gated by lock so a lost lock kills the pulse in the same cycle.
  assign phase_step = (state_q == STEP_HI) && pll_locked;
  assign busy       = (state_q == PLAN) || (state_q == STEP_HI) ||
                      (state_q == SETTLE) || (state_q == FAULT);
  assign req_ready  = (state_q == IDLE) && pll_locked && !done_q;
  assign phase_updn = updn_q;
  assign cur_phase  = cur_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_phase_step_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ddr_phase_step_ctrl : directed self-checking bench for ddr_phase_step_ctrl
// Rev 1.0
// ============================================================================
module tb_ddr_phase_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       req_valid;
  logic       req_ready;
  logic       req_rel;
  logic [3:0] req_phase;
  logic       phase_step;
  logic       phase_updn;
  logic [3:0] cur_phase;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_phase_step_ctrl #(
    .PHASE_STEPS   (16),
    .RESET_PHASE   (4),
    .STEP_PULSE_CYC(2),
    .SETTLE_CYC    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rel   (req_rel),
    .req_phase (req_phase),
    .phase_step(phase_step),
    .phase_updn(phase_updn),
    .cur_phase (cur_phase),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to completion; done lands in cycle 2+k*10.
  task automatic do_req(input string tag, input logic rel, input logic [3:0] ph,
                        input int k, input logic up, input logic [3:0] fin);
    int   dc, pulses, hi, first_hi, done_cnt, done_at, updn_bad;
    logic prev;
    dc = 2 + k * 10;
    pulses = 0; hi = 0; first_hi = -1; done_cnt = 0; done_at = -1; updn_bad = 0;
    prev = 1'b0;
    check({tag, "/ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_rel   = rel;
    req_phase = ph;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= dc + 1; c++) begin
      if (c == 1) begin
        check({tag, "/busy_plan"}, 32'(busy), 32'd1);
        check({tag, "/err_cleared"}, 32'(err), 32'd0);
      end
      if (phase_step === 1'b1) begin
        hi++;
        if (!prev) begin
          pulses++;
          if (first_hi < 0) first_hi = c;
        end
      end
      prev = phase_step;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c >= 2 && c < dc && phase_updn !== up) updn_bad++;
      if (c == dc) check({tag, "/ready_at_done"}, 32'(req_ready), 32'd0);
      if (c != dc + 1) tick();
    end
    check({tag, "/pulses"}, 32'(pulses), 32'(k));
    check({tag, "/hi_cycles"}, 32'(hi), 32'(2 * k));
    check({tag, "/first_rise"}, 32'(first_hi), (k > 0) ? 32'd2 : 32'hFFFF_FFFF);
    check({tag, "/done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "/done_cycle"}, 32'(done_at), 32'(dc));
    check({tag, "/updn"}, 32'(updn_bad), 32'd0);
    check({tag, "/cur_phase"}, 32'(cur_phase), 32'(fin));
    check({tag, "/err"}, 32'(err), 32'd0);
    check({tag, "/ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int early_act;
    rst = 1'b1; pll_locked = 1'b0; req_valid = 1'b0; req_rel = 1'b0; req_phase = 4'd0;
    tick();
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/phase_step", 32'(phase_step), 32'd0);
    check("rst/phase_updn", 32'(phase_updn), 32'd0);
    check("rst/cur_phase", 32'(cur_phase), 32'd4);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    early_act = 0;
    for (int i = 2; i < 10; i++) begin
      tick();
      if (req_ready !== 1'b0 || phase_step !== 1'b0 || busy !== 1'b0) early_act++;
    end
    check("unlocked/activity", 32'(early_act), 32'd0);
    pll_locked = 1'b1;
    tick();
    tick();
    check("lock/req_ready", 32'(req_ready), 32'd1);
    check("lock/cur_phase", 32'(cur_phase), 32'd4);
    check("lock/phase_step", 32'(phase_step), 32'd0);

    do_req("abs7",   1'b0, 4'd7,  3, 1'b1, 4'd7);
    do_req("abs4",   1'b0, 4'd4,  3, 1'b0, 4'd4);
    do_req("abs14",  1'b0, 4'd14, 6, 1'b0, 4'd14);
    do_req("back4",  1'b0, 4'd4,  6, 1'b1, 4'd4);
    do_req("tie12",  1'b0, 4'd12, 8, 1'b1, 4'd12);
    do_req("abs0",   1'b0, 4'd0,  4, 1'b1, 4'd0);
    do_req("rel_m1", 1'b1, 4'hF,  1, 1'b0, 4'd15);
    do_req("same15", 1'b0, 4'd15, 0, 1'b1, 4'd15);
    do_req("rel_p2", 1'b1, 4'd2,  2, 1'b1, 4'd1);

    // Lock lost during the first step pulse
    req_valid = 1'b1; req_rel = 1'b0; req_phase = 4'd5;
    tick();
    req_valid = 1'b0;
    tick();
    check("fault/step_before", 32'(phase_step), 32'd1);
    pll_locked = 1'b0;
    #1;
    check("fault/step_same_cycle", 32'(phase_step), 32'd0);
    tick();
    check("fault/done", 32'(done), 32'd1);
    check("fault/err", 32'(err), 32'd1);
    check("fault/cur_phase", 32'(cur_phase), 32'd4);
    check("fault/busy", 32'(busy), 32'd1);
    tick();
    check("fault/done_once", 32'(done), 32'd0);
    check("fault/ready_unlocked", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_phase = 4'd9;
    pll_locked = 1'b1;
    tick();
    req_valid = 1'b0;
    check("relock/busy_ignored", 32'(busy), 32'd0);
    check("relock/ready", 32'(req_ready), 32'd1);
    check("relock/err_sticky", 32'(err), 32'd1);

    do_req("clr5", 1'b0, 4'd5, 1, 1'b1, 4'd5);

    // Lock lost while idle
    pll_locked = 1'b0;
    #1;
    check("idle_unlock/ready", 32'(req_ready), 32'd0);
    tick();
    check("idle_unlock/cur_phase", 32'(cur_phase), 32'd4);
    check("idle_unlock/err", 32'(err), 32'd0);
    pll_locked = 1'b1;
    tick();
    check("idle_unlock/ready_back", 32'(req_ready), 32'd1);

    // Reset in the middle of an operation
    req_valid = 1'b1; req_rel = 1'b0; req_phase = 4'd12;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("midrst/cur_before", 32'(cur_phase), 32'd5);
    check("midrst/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/cur_phase", 32'(cur_phase), 32'd4);
    check("midrst/updn", 32'(phase_updn), 32'd0);
    check("midrst/step", 32'(phase_step), 32'd0);
    check("midrst/ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("midrst/ready_back", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
